// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential binary32 divider, d = s / t.
// Bit-serial restoring divide of the significands (26 quotient bits), then
// round-to-nearest-even and exponent range checks. Denormals flush to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready=1, waiting for req; operands latched on accept
// DIV   | one restoring-divide iteration per cycle, 26 in total
// ROUND | normalise, round, resolve special cases, pulse done
module fdiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic        ready,
  output logic        done,
  output logic [31:0] d,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] s_q, s_d, t_q, t_d;
  logic [24:0] r_q, r_d;
  logic [25:0] q_q, q_d;
  logic        done_q, done_d;
  logic [31:0] d_q, d_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

  logic        s_zero, s_inf, s_nan, t_zero, t_inf, t_nan, sign;
  logic [24:0] dvs, r_sub, r_next;
  logic        q_bit;
  logic [22:0] mant;
  logic        guard, rnd, sticky, up, adj;
  logic [23:0] mant_r;
  logic [9:0]  exp_r;

  assign s_zero = (s_q[30:23] == 8'd0);
  assign s_inf  = (s_q[30:23] == 8'hFF) && (s_q[22:0] == 23'd0);
  assign s_nan  = (s_q[30:23] == 8'hFF) && (s_q[22:0] != 23'd0);
  assign t_zero = (t_q[30:23] == 8'd0);
  assign t_inf  = (t_q[30:23] == 8'hFF) && (t_q[22:0] == 23'd0);
  assign t_nan  = (t_q[30:23] == 8'hFF) && (t_q[22:0] != 23'd0);
  assign sign   = s_q[31] ^ t_q[31];

  assign ready       = (state_q == IDLE);
  assign done        = done_q;
  assign d           = d_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;

  // One restoring step: remainder stays below 2*divisor so 25 bits suffice.
  always_comb begin
    dvs    = {2'b01, t_q[22:0]};
    q_bit  = (r_q >= dvs);
    r_sub  = q_bit ? (r_q - dvs) : r_q;
    r_next = {r_sub[23:0], 1'b0};
  end

  // Normalise the 26-bit quotient, round to nearest even, form the exponent.
  always_comb begin
    mant  = q_q[23:1];
    guard = q_q[0];
    rnd   = 1'b0;
    adj   = 1'b1;
    if (q_q[25]) begin
      mant  = q_q[24:2];
      guard = q_q[1];
      rnd   = q_q[0];
      adj   = 1'b0;
    end
    sticky = |r_q;
    up     = guard & (rnd | sticky | mant[0]);
    mant_r = {1'b0, mant} + {23'd0, up};
    // 10-bit two's complement; bit 9 set means the result went negative.
    exp_r  = {2'b00, s_q[30:23]} - {2'b00, t_q[30:23]} + 10'd127
             - {9'd0, adj} + {9'd0, mant_r[23]};
  end

  // Next-state, datapath loads and result selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    t_d     = t_q;
    r_d     = r_q;
    q_d     = q_q;
    done_d  = 1'b0;
    d_d     = d_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DIV;
          cnt_d   = 5'd25;
          s_d     = s;
          t_d     = t;
          r_d     = {2'b01, s[22:0]};
          q_d     = '0;
        end
      end
      DIV: begin
        r_d = r_next;
        q_d = {q_q[24:0], q_bit};
        if (cnt_q == 5'd0) state_d = ROUND;
        else               cnt_d   = cnt_q - 5'd1;
      end
      ROUND: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        dbz_d   = 1'b0;
        if (s_nan) begin
          d_d = {s_q[31], 8'hFF, 1'b1, s_q[21:0]};
        end else if (t_nan) begin
          d_d = {t_q[31], 8'hFF, 1'b1, t_q[21:0]};
        end else if ((s_inf && t_inf) || (s_zero && t_zero)) begin
          d_d = 32'h7FC0_0000;
        end else if (s_inf || t_zero) begin
          d_d   = {sign, 8'hFF, 23'd0};
          dbz_d = ~s_inf;
        end else if (s_zero || t_inf) begin
          d_d = {sign, 31'd0};
        end else if (!exp_r[9] && (exp_r >= 10'd255)) begin
          d_d   = {sign, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (exp_r[9] || (exp_r == 10'd0)) begin
          d_d   = {sign, 31'd0};
          unf_d = 1'b1;
        end else begin
          d_d = {sign, exp_r[7:0], mant_r[22:0]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      t_q     <= t_d;
      r_q     <= r_d;
      q_q     <= q_d;
      done_q  <= done_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: randomized and directed bench for fdiv_seq against an
// arithmetic reference (exact integer long division + nearest-even rounding).
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic [31:0] s = '0;
  logic [31:0] t = '0;
  logic        ready, done, overflow, underflow, div_by_zero;
  logic [31:0] d;

  int checks = 0;
  int errors = 0;

  fdiv_seq dut (
    .clk(clk), .rstn(rstn), .req(req), .s(s), .t(t),
    .ready(ready), .done(done), .d(d),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference result packed as {overflow, underflow, div_by_zero, d}.
  function automatic logic [34:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sg, a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [22:0] fa, fb;
    int ea, eb, e, adj;
    longint unsigned ma, mb, num, sig, rem;
    sa = a[31]; sb = b[31]; sg = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    a_zero = (ea == 0); a_inf = (ea == 255) && (fa == 0); a_nan = (ea == 255) && (fa != 0);
    b_zero = (eb == 0); b_inf = (eb == 255) && (fb == 0); b_nan = (eb == 255) && (fb != 0);
    if (a_nan) return {3'b000, sa, 8'hFF, 1'b1, fa[21:0]};
    if (b_nan) return {3'b000, sb, 8'hFF, 1'b1, fb[21:0]};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {3'b000, 32'h7FC00000};
    if (a_inf || b_zero) return {2'b00, !a_inf, sg, 8'hFF, 23'd0};
    if (a_zero || b_inf) return {3'b000, sg, 31'd0};
    ma = {40'd0, 1'b1, fa};
    mb = {40'd0, 1'b1, fb};
    adj = (ma < mb) ? 1 : 0;
    num = ma << (23 + adj);
    sig = num / mb;
    rem = num % mb;
    if (((rem << 1) > mb) || (((rem << 1) == mb) && sig[0])) sig = sig + 1;
    e = ea - eb + 127 - adj;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b100, sg, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, sg, 31'd0};
    return {3'b000, sg, e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(100, 154));
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = 23'($urandom);
    if ($urandom_range(0, 5) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // Transaction-level model: busy for 27 edges after an accept.
  int          cyc = 0;
  int          m_cnt = 0;
  int          m_acc_cyc = 0;
  logic        m_done = 1'b0;
  logic [34:0] m_out = '0;
  logic [34:0] m_pend = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (req) begin
          m_cnt     <= 27;
          m_pend    <= fdiv_ref(s, t);
          m_acc_cyc <= cyc;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_out  <= m_pend;
        end
      end
    end
  end

  int n_done = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    checks++;
    if (ready !== (m_cnt == 0)) begin
      errors++;
      $display("FAIL ready @%0d: got %b want %b", cyc, ready, (m_cnt == 0));
    end
    checks++;
    if (done !== m_done) begin
      errors++;
      $display("FAIL done @%0d: got %b want %b", cyc, done, m_done);
    end
    checks++;
    if ({overflow, underflow, div_by_zero, d} !== m_out) begin
      errors++;
      $display("FAIL result @%0d: got flags=%b d=%h want flags=%b d=%h", cyc,
               {overflow, underflow, div_by_zero}, d, m_out[34:32], m_out[31:0]);
    end
    if (done === 1'b1) begin
      n_done++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc - 1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && m_cnt != 0; i++) tick();
    checks++;
    if (m_cnt != 0) begin
      errors++;
      $display("FAIL wait_idle: got busy count %0d want 0", m_cnt);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    s = a;
    t = b;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  localparam int NLIT = 16;
  logic [31:0] lit_s [NLIT] = '{
    32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
    32'h00000000, 32'h7FA00000, 32'h7F000000, 32'h01000000,
    32'h81000000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
    32'h3F800000, 32'hC0C00000, 32'h00400000, 32'h3F800000};
  logic [31:0] lit_t [NLIT] = '{
    32'h40400000, 32'h40400000, 32'h3F800000, 32'h00000000,
    32'h00000000, 32'h3F800000, 32'h3E800000, 32'h42000000,
    32'h42000000, 32'h00000000, 32'h7F800000, 32'hFFC00001,
    32'h3F7FFFFF, 32'h40400000, 32'h3F800000, 32'h80000000};
  logic [34:0] lit_e [NLIT] = '{
    35'h0_40000000, 35'h0_3EAAAAAB, 35'h0_3F800000, 35'h1_7F800000,
    35'h0_7FC00000, 35'h0_7FE00000, 35'h4_7F800000, 35'h2_00000000,
    35'h2_80000000, 35'h0_7F800000, 35'h0_00000000, 35'h0_FFC00001,
    35'h0_3F800001, 35'h0_C0000000, 35'h0_00000000, 35'h1_FF800000};

  task automatic run_lit(input int i);
    logic [34:0] r;
    r = fdiv_ref(lit_s[i], lit_t[i]);
    checks++;
    if (r !== lit_e[i]) begin
      errors++;
      $display("FAIL ref_lit%0d: got %h want %h", i, r, lit_e[i]);
    end
    start(lit_s[i], lit_t[i]);
    wait_idle();
    checks++;
    if (done !== 1'b1 || {overflow, underflow, div_by_zero, d} !== lit_e[i]) begin
      errors++;
      $display("FAIL dut_lit%0d: got done=%b %h want done=1 %h", i, done,
               {overflow, underflow, div_by_zero, d}, lit_e[i]);
    end
    checks++;
    if (last_done_cyc - m_acc_cyc != 27) begin
      errors++;
      $display("FAIL latency_lit%0d: got %0d want 27", i, last_done_cyc - m_acc_cyc);
    end
  endtask

  int n0;

  initial begin
    tick();
    tick();
    checks++;
    if ({ready, done, overflow, underflow, div_by_zero, d} !== {1'b1, 36'd0}) begin
      errors++;
      $display("FAIL reset_state: got ready=%b done=%b d=%h", ready, done, d);
    end
    #2 rstn = 1'b1;
    tick();

    for (int i = 0; i < NLIT; i++) run_lit(i);

    // Requests while busy must be ignored.
    wait_idle();
    n0 = n_done;
    start(32'h40C00000, 32'h40400000);
    repeat (4) tick();
    s = 32'h3F800000; t = 32'h40400000; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    s = 32'h7F000000; t = 32'h3E800000; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (25) tick();
    checks++;
    if (n_done - n0 != 1) begin
      errors++;
      $display("FAIL ignore_busy_req: got %0d dones want 1", n_done - n0);
    end

    // Continuous req: one result every 28 cycles.
    wait_idle();
    n0 = n_done;
    s = 32'h3F800000; t = 32'h40400000; req = 1'b1;
    repeat (86) tick();
    req = 1'b0;
    checks++;
    if (n_done - n0 != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones want 3", n_done - n0);
    end
    checks++;
    if (last_done_cyc - prev_done_cyc != 28) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 28", last_done_cyc - prev_done_cyc);
    end
    wait_idle();

    // Reset in the middle of an operation aborts it.
    start(32'h40C00000, 32'h40400000);
    repeat (11) tick();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({ready, done, overflow, underflow, div_by_zero, d} !== {1'b1, 36'd0}) begin
      errors++;
      $display("FAIL abort_reset: got ready=%b done=%b flags=%b d=%h", ready, done,
               {overflow, underflow, div_by_zero}, d);
    end
    repeat (3) tick();
    #2 rstn = 1'b1;
    n0 = n_done;
    repeat (40) tick();
    checks++;
    if (n_done != n0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones want 0", n_done - n0);
    end
    run_lit(1);

    // Randomized operands, with occasional ignored requests while busy.
    for (int k = 0; k < 250; k++) begin
      start(gen_op(), gen_op());
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        s = gen_op(); t = gen_op(); req = 1'b1;
        tick();
        req = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
